// File: rtl/lsu_axi_rd_slv_if.sv
// lsu_axi_rd_slv_if: LSU read request (AR) and read response (R) channels
interface lsu_axi_rd_slv_if #(
  parameter int AW  = 10,
  parameter int DW  = 64,
  parameter int IDW = 8
);
  logic [IDW-1:0] lsu_axi_arid;
  logic [AW-1:0]  lsu_axi_araddr;
  logic [7:0]     lsu_axi_arlen;
  logic [2:0]     lsu_axi_arsize;
  logic [1:0]     lsu_axi_arburst;
  logic [2:0]     lsu_axi_arstr;
  logic [7:0]     lsu_axi_arnum;
  logic           lsu_axi_arvld;
  logic           axi_lsu_arrdy;
  logic [IDW-1:0] axi_lsu_rid;
  logic [DW-1:0]  axi_lsu_rdata;
  logic [1:0]     axi_lsu_rresp;
  logic           axi_lsu_rlast;
  logic           axi_lsu_rvld;
  logic           lsu_axi_rrdy;
  modport master (
    output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
    input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
  );
  modport slave (
    input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
    output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
  );
endinterface

// File: rtl/lsu_axi_rd_slv.sv
// lsu_axi_rd_slv: strided 2-D AXI-style read responder over a 64-bit synchronous SRAM
module lsu_axi_rd_slv #(
  parameter int AW  = 10,
  parameter int DW  = 64,
  parameter int IDW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_axi_rd_slv_if.slave bus,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic [DW-1:0]   mem_rd_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic arrdy, err, inflight, inflight_last, wp, rp;
  logic [IDW-1:0] id;
  logic [AW-1:0] row_base, pitch;
  logic [7:0] len, num, r, b;
  logic [2:0] str;
  logic [1:0] cnt;
  logic [DW-1:0] buf_data [2];
  logic [1:0] buf_resp [2];
  logic buf_last [2];
  logic ar_hs, pop, issue, row_end, last_beat, empty, push, fifo_pop;
  logic [DW-1:0] in_data;
  logic [1:0] in_resp;

  assign ar_hs = bus.lsu_axi_arvld & arrdy;
  assign empty = cnt == 2'd0;
  assign pop = bus.axi_lsu_rvld & bus.lsu_axi_rrdy;
  assign row_end = b == len;
  assign last_beat = row_end && r == num;
  assign pitch = AW'({1'b0, len} + 9'd1) << str;
  assign in_data = err ? '0 : mem_rd_data;
  assign in_resp = err ? 2'b10 : 2'b00;
  assign push = inflight & ~(empty & bus.lsu_axi_rrdy);
  assign fifo_pop = ~empty & bus.lsu_axi_rrdy;

  assign bus.axi_lsu_arrdy = arrdy;
  assign bus.axi_lsu_rid = id;
  assign bus.axi_lsu_rvld = ~empty | inflight;
  assign bus.axi_lsu_rdata = ~empty ? buf_data[rp] : inflight ? in_data : '0;
  assign bus.axi_lsu_rresp = ~empty ? buf_resp[rp] : inflight ? in_resp : 2'b00;
  assign bus.axi_lsu_rlast = ~empty ? buf_last[rp] : inflight & inflight_last;

  // next state and credit-gated SRAM issue; a beat popped this cycle frees its slot
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    case (state)
      IDLE: state_nx = ar_hs ? ISSUE : IDLE;
      ISSUE: begin
        issue = {1'b0, cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop};
        state_nx = issue && last_beat ? DRAIN : ISSUE;
      end
      DRAIN: state_nx = pop && bus.axi_lsu_rlast ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
    mem_rd_en = issue & ~err;
    mem_rd_addr = mem_rd_en ? row_base + AW'(b) : '0;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // request capture, registered ready and row/beat walk with an incremental row base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrdy <= 1'b0;
      id <= '0;
      err <= 1'b0;
      len <= '0;
      num <= '0;
      str <= '0;
      r <= '0;
      b <= '0;
      row_base <= '0;
    end else begin
      arrdy <= state_nx == IDLE;
      if (ar_hs) begin
        id <= bus.lsu_axi_arid;
        row_base <= bus.lsu_axi_araddr;
        len <= bus.lsu_axi_arlen;
        num <= bus.lsu_axi_arnum;
        str <= bus.lsu_axi_arstr;
        err <= bus.lsu_axi_arsize != 3'd3 || bus.lsu_axi_arburst != 2'b01;
        r <= '0;
        b <= '0;
      end else if (issue) begin
        b <= row_end ? 8'd0 : b + 8'd1;
        if (row_end) begin
          r <= r + 8'd1;
          row_base <= row_base + pitch;
        end
      end
    end
  end

  // tracks the SRAM read whose data lands this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      inflight_last <= issue & last_beat;
    end
  end

  // output buffer pointers and occupancy; an arriving beat bypasses an empty buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (fifo_pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  // output buffer storage; slot contents are meaningless while unoccupied
  always_ff @(posedge clk)
    if (push) begin
      buf_data[wp] <= in_data;
      buf_resp[wp] <= in_resp;
      buf_last[wp] <= inflight_last;
    end
endmodule

// File: tb/tb_lsu_axi_rd_slv.sv
// tb_lsu_axi_rd_slv: randomized checks of lsu_axi_rd_slv against a 2-D stride reference model
module tb_lsu_axi_rd_slv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_rd_en;
  logic [9:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [63:0] mem [1024];

  lsu_axi_rd_slv_if #(.AW(10), .DW(64), .IDW(8)) bus ();
  lsu_axi_rd_slv #(.AW(10), .DW(64), .IDW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  typedef struct { logic [63:0] d; logic [1:0] rs; logic l; } beat_t;
  beat_t exp_beat[$];
  int exp_addr[$];
  int n_chk, n_fail, cyc, t_hs, last_acc, acc_txn, issued, acc_ok, pc, mode;
  logic [7:0] exp_id;
  bit busy, ret_pend, seen_rd, seen_rv;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus.axi_lsu_arrdy, bus.axi_lsu_rvld, bus.axi_lsu_rlast, bus.axi_lsu_rid,
                        bus.axi_lsu_rresp, mem_rd_en, mem_rd_addr}, 0);
    chk({tag, "_rdata"}, bus.axi_lsu_rdata, 0);
  endtask

  task automatic monitor();
    beat_t e;
    if (!rst_n) return;
    if (busy) chk("arrdy_busy", bus.axi_lsu_arrdy, 0);
    if (ret_pend) begin
      chk("arrdy_ret", bus.axi_lsu_arrdy, 1);
      ret_pend = 0;
    end
    if (mem_rd_en) begin
      if (!seen_rd) begin
        chk("rd_lat", cyc - t_hs, 1);
        seen_rd = 1;
      end
      if (exp_addr.size() == 0) chk("rd_extra", mem_rd_en, 0);
      else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
      issued++;
    end
    if (bus.axi_lsu_rvld) begin
      if (!seen_rv) begin
        chk("rv_lat", cyc - t_hs, 2);
        seen_rv = 1;
      end
      if (exp_beat.size() == 0) chk("rv_extra", bus.axi_lsu_rvld, 0);
      else begin
        e = exp_beat[0];
        chk("rdata", bus.axi_lsu_rdata, e.d);
        chk("rresp", bus.axi_lsu_rresp, e.rs);
        chk("rlast", bus.axi_lsu_rlast, e.l);
        chk("rid", bus.axi_lsu_rid, exp_id);
        if (bus.lsu_axi_rrdy) begin
          void'(exp_beat.pop_front());
          acc_txn++;
          last_acc = cyc;
          if (e.rs == 2'b00) acc_ok++;
          if (e.l) begin
            busy = 0;
            ret_pend = 1;
          end
        end
      end
    end
    if (mem_rd_en) chk("occ", (issued - acc_ok) <= 2, 1);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    pc++;
    bus.lsu_axi_rrdy = mode == 0 ? 1'b1 : mode == 1 ? (pc % 4 == 0 || pc % 4 == 3) : 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] id, input int addr, input int len, input int size,
                      input int burst, input int str, input int num);
    int n = 0;
    int a;
    bit e;
    while (!bus.axi_lsu_arrdy && n < 200) begin
      tick();
      n++;
    end
    chk("arrdy_wait", bus.axi_lsu_arrdy, 1);
    e = size != 3 || burst != 1;
    exp_id = id;
    for (int r = 0; r <= num; r++)
      for (int b = 0; b <= len; b++) begin
        a = (addr + r * ((len + 1) << str) + b) % 1024;
        if (!e) exp_addr.push_back(a);
        exp_beat.push_back('{e ? 64'd0 : mem[a], e ? 2'b10 : 2'b00, r == num && b == len});
      end
    bus.lsu_axi_arid = id;
    bus.lsu_axi_araddr = 10'(addr);
    bus.lsu_axi_arlen = 8'(len);
    bus.lsu_axi_arsize = 3'(size);
    bus.lsu_axi_arburst = 2'(burst);
    bus.lsu_axi_arstr = 3'(str);
    bus.lsu_axi_arnum = 8'(num);
    bus.lsu_axi_arvld = 1'b1;
    t_hs = cyc;
    seen_rd = 0;
    seen_rv = 0;
    acc_txn = 0;
    tick();
    bus.lsu_axi_arvld = 1'b0;
    bus.lsu_axi_araddr = 10'($urandom);
    bus.lsu_axi_arlen = 8'($urandom);
    busy = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || exp_beat.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("done", busy || exp_beat.size() != 0, 0);
    exp_beat.delete();
    exp_addr.delete();
    busy = 0;
  endtask

  initial begin
    int k;
    bit bad;
    mode = 0;
    bus.lsu_axi_arid = '0;
    bus.lsu_axi_araddr = '0;
    bus.lsu_axi_arlen = '0;
    bus.lsu_axi_arsize = '0;
    bus.lsu_axi_arburst = '0;
    bus.lsu_axi_arstr = '0;
    bus.lsu_axi_arnum = '0;
    bus.lsu_axi_arvld = 1'b0;
    bus.lsu_axi_rrdy = 1'b1;
    foreach (mem[i]) mem[i] = {$urandom, $urandom};
    for (int i = 'h10; i < 'h14; i++) mem[i] = 64'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("arrdy_init", bus.axi_lsu_arrdy, 1);

    send(8'h11, 'h010, 3, 3, 1, 0, 0);
    wait_done();
    chk("thru_row", last_acc - t_hs, 5);
    send(8'h22, 'h100, 1, 3, 1, 2, 2);
    wait_done();
    chk("thru_2d", last_acc - t_hs, 7);
    send(8'h33, 'h3FE, 3, 3, 1, 0, 0);
    wait_done();
    chk("thru_wrap", last_acc - t_hs, 5);

    mode = 1;
    pc = 0;
    send(8'h44, 'h055, 7, 3, 1, 0, 0);
    wait_done();

    mode = 0;
    send(8'h55, 'h020, 2, 2, 1, 0, 0);
    wait_done();
    chk("thru_err", last_acc - t_hs, 4);
    send(8'h56, 'h030, 1, 3, 1, 0, 0);
    wait_done();

    mode = 2;
    repeat (20) begin
      bad = $urandom_range(0, 4) == 0;
      k = $urandom_range(0, 1);
      send(8'($urandom), $urandom_range(0, 1023), $urandom_range(0, 7),
           bad && k == 0 ? $urandom_range(0, 2) : 3,
           bad && k == 1 ? ($urandom_range(0, 1) ? 0 : 2) : 1,
           $urandom_range(0, 7), $urandom_range(0, 3));
      wait_done();
    end

    mode = 0;
    send(8'h77, 'h200, 7, 3, 1, 0, 0);
    k = 0;
    while (acc_txn < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("pre_rst_beats", acc_txn, 2);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    exp_beat.delete();
    exp_addr.delete();
    busy = 0;
    ret_pend = 0;
    issued = 0;
    acc_ok = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arrdy_rel", bus.axi_lsu_arrdy, 1);
    send(8'h78, 'h2A0, 0, 3, 1, 0, 0);
    wait_done();
    chk("one_beat", acc_txn, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
